// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, default widths, PC step and NOP.
package instruction_fetch_pkg;

  localparam int unsigned XLEN_DEF    = 64;
  localparam int unsigned ILEN_DEF    = 32;
  localparam int unsigned PC_STEP_DEF = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Bus bundle between the fetch stage, instruction memory, decode and the redirect/halt sources.
interface instruction_fetch_if
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned ILEN = ILEN_DEF
);
  logic [XLEN-1:0] imem_address;
  logic            imem_enable;
  logic            imem_read;
  logic [ILEN-1:0] imem_data_in;
  logic [ILEN-1:0] imem_data_out;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            halt_req;
  logic            id_valid;
  logic [ILEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;
  logic            id_ready;
  logic            fetch_fault;

  modport master (
    output imem_address, imem_enable, imem_read, imem_data_in,
    output id_valid, id_instr, id_pc, fetch_fault,
    input  imem_data_out, redirect_valid, redirect_pc, halt_req, id_ready
  );

  modport slave (
    input  imem_address, imem_enable, imem_read, imem_data_in,
    input  id_valid, id_instr, id_pc, fetch_fault,
    output imem_data_out, redirect_valid, redirect_pc, halt_req, id_ready
  );
endinterface

// File: rtl/instruction_fetch_if_id_reg.sv
// IF/ID pipeline register: valid/ready hold, load on fetch, flush has priority over load.
module instruction_fetch_if_id_reg #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned ILEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic            i_flush,
  input  logic            i_ready,
  input  logic [ILEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  output logic [ILEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc
);

  logic            r_valid;
  logic [ILEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, BOOT/RUN/HALT FSM, redirect/halt handling, IF/ID capture.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirects halt and raise a sticky fetch_fault.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter int unsigned     ILEN     = ILEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = PC_STEP_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  instruction_fetch_if.master bus
);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_redirect_tgt;
  logic            w_trap;
  logic            w_fire;
  logic            w_id_valid;
  logic [ILEN-1:0] w_id_instr;
  logic [XLEN-1:0] w_id_pc;

  // A redirect discards whatever the memory returns this cycle, so it blocks the fire.
  assign w_fire = (r_state == ST_RUN) && (!w_id_valid || bus.id_ready) && !bus.redirect_valid;

  always_comb begin
    w_redirect_tgt = bus.redirect_pc;
    w_trap         = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    w_trap = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
`else
    w_redirect_tgt[1:0] = 2'b00;
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    if (bus.redirect_valid) begin
      if (w_trap) begin
        w_state_nxt = ST_HALT;
      end else begin
        w_state_nxt = ST_RUN;
        w_pc_nxt    = w_redirect_tgt;
      end
    end else begin
      case (r_state)
        ST_BOOT: w_state_nxt = ST_RUN;
        ST_RUN: begin
          if (w_fire)       w_pc_nxt    = r_pc + XLEN'(PC_STEP);
          if (bus.halt_req) w_state_nxt = ST_HALT;
        end
        ST_HALT: w_state_nxt = ST_HALT;
        default: w_state_nxt = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_fault;

  always_ff @(posedge clk) begin
    if (!rst_n) r_fault <= 1'b0;
    else if (w_trap) r_fault <= 1'b1;
  end

  assign bus.fetch_fault = r_fault;
`else
  assign bus.fetch_fault = 1'b0;
`endif

  instruction_fetch_if_id_reg #(
    .XLEN(XLEN),
    .ILEN(ILEN)
  ) u_if_id_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_fire),
    .i_flush(bus.redirect_valid),
    .i_ready(bus.id_ready),
    .i_instr(bus.imem_data_out),
    .i_pc   (r_pc),
    .o_valid(w_id_valid),
    .o_instr(w_id_instr),
    .o_pc   (w_id_pc)
  );

  assign bus.imem_address = r_pc;
  assign bus.imem_enable  = (r_state == ST_RUN);
  assign bus.imem_read    = 1'b1;
  assign bus.imem_data_in = '0;
  assign bus.id_valid     = w_id_valid;
  assign bus.id_instr     = w_id_instr;
  assign bus.id_pc        = w_id_pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; checks follow FETCH_MISALIGN_TRAP_EN when defined.
module tb_instruction_fetch;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  instruction_fetch_if #(.XLEN(64), .ILEN(32)) bus ();

  instruction_fetch #(
    .XLEN    (64),
    .ILEN    (32),
    .RESET_PC(64'd0),
    .PC_STEP (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Memory image: every word is a distinct function of its address.
  function automatic logic [31:0] mem(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  assign bus.imem_data_out = mem(bus.imem_address);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.id_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.halt_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (bus.id_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", bus.id_valid); end
    tests++; if (bus.id_pc !== 64'd0) begin fails++; $display("FAIL rst_id_pc: got %h want 0", bus.id_pc); end
    tests++; if (bus.id_instr !== 32'd0) begin fails++; $display("FAIL rst_id_instr: got %h want 0", bus.id_instr); end
    tests++; if (bus.imem_address !== 64'd0) begin fails++; $display("FAIL rst_addr: got %h want 0", bus.imem_address); end
    tests++; if (bus.imem_enable !== 1'b0) begin fails++; $display("FAIL rst_enable: got %b want 0", bus.imem_enable); end
    tests++; if (bus.fetch_fault !== 1'b0) begin fails++; $display("FAIL rst_fault: got %b want 0", bus.fetch_fault); end
    tests++; if (bus.imem_read !== 1'b1) begin fails++; $display("FAIL rst_read: got %b want 1", bus.imem_read); end
    tests++; if (bus.imem_data_in !== 32'd0) begin fails++; $display("FAIL rst_data_in: got %h want 0", bus.imem_data_in); end
  endtask

  task automatic test_sequential();
    rst_n = 1'b1;
    tick();  // BOOT -> RUN
    tests++; if (bus.id_valid !== 1'b0) begin fails++; $display("FAIL seq_boot_valid: got %b want 0", bus.id_valid); end
    tests++; if (bus.imem_enable !== 1'b1) begin fails++; $display("FAIL seq_enable: got %b want 1", bus.imem_enable); end
    tests++; if (bus.imem_address !== 64'd0) begin fails++; $display("FAIL seq_addr0: got %h want 0", bus.imem_address); end
    for (int unsigned k = 0; k < 3; k++) begin
      tick();
      tests++; if (bus.id_valid !== 1'b1) begin fails++; $display("FAIL seq_valid[%0d]: got %b want 1", k, bus.id_valid); end
      tests++; if (bus.id_pc !== 64'(4 * k)) begin fails++; $display("FAIL seq_pc[%0d]: got %h want %h", k, bus.id_pc, 4 * k); end
      tests++; if (bus.id_instr !== mem(64'(4 * k))) begin fails++; $display("FAIL seq_instr[%0d]: got %h want %h", k, bus.id_instr, mem(64'(4 * k))); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    rst_n = 1'b1;
    tick();
    tick();
    tick();  // id_pc=4, address=8
    bus.id_ready = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      tick();
      tests++; if (bus.id_pc !== 64'd4) begin fails++; $display("FAIL stall_pc[%0d]: got %h want 4", k, bus.id_pc); end
      tests++; if (bus.id_instr !== mem(64'd4)) begin fails++; $display("FAIL stall_instr[%0d]: got %h want %h", k, bus.id_instr, mem(64'd4)); end
      tests++; if (bus.imem_address !== 64'd8) begin fails++; $display("FAIL stall_addr[%0d]: got %h want 8", k, bus.imem_address); end
      tests++; if (bus.id_valid !== 1'b1) begin fails++; $display("FAIL stall_valid[%0d]: got %b want 1", k, bus.id_valid); end
    end
    bus.id_ready = 1'b1;
    tick();
    tests++; if (bus.id_pc !== 64'd8) begin fails++; $display("FAIL stall_release_pc: got %h want 8", bus.id_pc); end
    tests++; if (bus.imem_address !== 64'd12) begin fails++; $display("FAIL stall_release_addr: got %h want c", bus.imem_address); end
  endtask

  task automatic test_redirect();
    bus.id_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'd16;
    tick();
    bus.redirect_valid = 1'b0;
    bus.id_ready = 1'b1;
    tests++; if (bus.id_valid !== 1'b0) begin fails++; $display("FAIL redir_flush: got %b want 0", bus.id_valid); end
    tests++; if (bus.imem_address !== 64'd16) begin fails++; $display("FAIL redir_addr: got %h want 10", bus.imem_address); end
    tick();
    tests++; if (bus.id_pc !== 64'd16) begin fails++; $display("FAIL redir_id_pc: got %h want 10", bus.id_pc); end
    tests++; if (bus.id_instr !== mem(64'd16)) begin fails++; $display("FAIL redir_instr: got %h want %h", bus.id_instr, mem(64'd16)); end
  endtask

  task automatic test_halt();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'd0;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    tick();  // id_pc=4, address=8
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    tests++; if (bus.id_pc !== 64'd8 || bus.id_valid !== 1'b1) begin fails++; $display("FAIL halt_last: got pc %h v %b want 8 v 1", bus.id_pc, bus.id_valid); end
    tests++; if (bus.imem_enable !== 1'b0) begin fails++; $display("FAIL halt_enable: got %b want 0", bus.imem_enable); end
    tests++; if (bus.imem_address !== 64'd12) begin fails++; $display("FAIL halt_addr: got %h want c", bus.imem_address); end
    tick();
    tick();
    tests++; if (bus.id_valid !== 1'b0) begin fails++; $display("FAIL halt_drain: got %b want 0", bus.id_valid); end
    tests++; if (bus.imem_address !== 64'd12) begin fails++; $display("FAIL halt_hold: got %h want c", bus.imem_address); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'd0;
    tick();
    bus.redirect_valid = 1'b0;
    tests++; if (bus.imem_enable !== 1'b1) begin fails++; $display("FAIL halt_resume_en: got %b want 1", bus.imem_enable); end
    tick();
    tests++; if (bus.id_pc !== 64'd0 || bus.id_valid !== 1'b1) begin fails++; $display("FAIL halt_resume_pc: got pc %h v %b want 0 v 1", bus.id_pc, bus.id_valid); end
  endtask

  task automatic test_redirect_and_halt();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'd4;
    bus.halt_req = 1'b1;
    tick();
    bus.redirect_valid = 1'b0;
    bus.halt_req = 1'b0;
    tests++; if (bus.imem_enable !== 1'b1) begin fails++; $display("FAIL rh_enable: got %b want 1", bus.imem_enable); end
    tests++; if (bus.id_valid !== 1'b0) begin fails++; $display("FAIL rh_flush: got %b want 0", bus.id_valid); end
    tick();
    tests++; if (bus.id_pc !== 64'd4 || bus.id_valid !== 1'b1) begin fails++; $display("FAIL rh_pc: got pc %h v %b want 4 v 1", bus.id_pc, bus.id_valid); end
  endtask

  task automatic test_misalign();
    // Address is 8 here.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'd6;
    tick();
    bus.redirect_valid = 1'b0;
    tests++; if (bus.id_valid !== 1'b0) begin fails++; $display("FAIL mis_flush: got %b want 0", bus.id_valid); end
`ifdef FETCH_MISALIGN_TRAP_EN
    tests++; if (bus.imem_address !== 64'd8) begin fails++; $display("FAIL mis_addr: got %h want 8", bus.imem_address); end
    tests++; if (bus.imem_enable !== 1'b0) begin fails++; $display("FAIL mis_enable: got %b want 0", bus.imem_enable); end
    tests++; if (bus.fetch_fault !== 1'b1) begin fails++; $display("FAIL mis_fault: got %b want 1", bus.fetch_fault); end
    tick();
    tests++; if (bus.fetch_fault !== 1'b1) begin fails++; $display("FAIL mis_sticky: got %b want 1", bus.fetch_fault); end
    tests++; if (bus.id_valid !== 1'b0) begin fails++; $display("FAIL mis_halted: got %b want 0", bus.id_valid); end
`else
    tests++; if (bus.imem_address !== 64'd4) begin fails++; $display("FAIL mis_addr: got %h want 4", bus.imem_address); end
    tests++; if (bus.fetch_fault !== 1'b0) begin fails++; $display("FAIL mis_fault: got %b want 0", bus.fetch_fault); end
    tick();
    tests++; if (bus.id_pc !== 64'd4 || bus.id_instr !== mem(64'd4)) begin fails++; $display("FAIL mis_fetch: got pc %h instr %h want 4", bus.id_pc, bus.id_instr); end
`endif
  endtask

  task automatic test_wrap();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    tests++; if (bus.id_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin fails++; $display("FAIL wrap_id_pc: got %h want fffffffffffffffc", bus.id_pc); end
    tests++; if (bus.imem_address !== 64'd0) begin fails++; $display("FAIL wrap_addr: got %h want 0", bus.imem_address); end
  endtask

  task automatic test_reset_mid_stall();
    bus.id_ready = 1'b0;
    tick();  // stalled at id_pc=0, address=4
    tests++; if (bus.id_pc !== 64'd0 || bus.imem_address !== 64'd4) begin fails++; $display("FAIL rms_setup: got pc %h addr %h want 0/4", bus.id_pc, bus.imem_address); end
    rst_n = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'd32;
    tick();
    bus.redirect_valid = 1'b0;
    tests++; if (bus.id_valid !== 1'b0) begin fails++; $display("FAIL rms_valid: got %b want 0", bus.id_valid); end
    tests++; if (bus.id_pc !== 64'd0) begin fails++; $display("FAIL rms_id_pc: got %h want 0", bus.id_pc); end
    tests++; if (bus.id_instr !== 32'd0) begin fails++; $display("FAIL rms_instr: got %h want 0", bus.id_instr); end
    tests++; if (bus.imem_address !== 64'd0) begin fails++; $display("FAIL rms_addr: got %h want 0", bus.imem_address); end
    tests++; if (bus.imem_enable !== 1'b0) begin fails++; $display("FAIL rms_enable: got %b want 0", bus.imem_enable); end
    tests++; if (bus.fetch_fault !== 1'b0) begin fails++; $display("FAIL rms_fault: got %b want 0", bus.fetch_fault); end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.id_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.halt_req = 1'b0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_halt();
    test_redirect_and_halt();
    test_misalign();
    // Re-enter RUN from a known PC before the wrap and reset checks.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'd0;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    test_wrap();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'd0;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
